// File: rtl/eth_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eth_parser_pkg
// Brief   : Shared types and constants for the inline Ethernet header parser.
// Revision: 1.0 - initial release
// ============================================================================
package eth_parser_pkg;

    localparam int          ETH_HDR_BYTES = 14;
    localparam logic [15:0] ETYPE_IPV4    = 16'h0800;
    localparam logic [15:0] ETYPE_IPV6    = 16'h86DD;
    localparam logic [15:0] ETYPE_ARP     = 16'h0806;
    localparam logic [15:0] ETYPE_VLAN    = 16'h8100;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic [11:0] vlan_id;
        logic        is_vlan;
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_arp;
        logic        runt;
    } eth_metadata_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } parse_state_t;

    // Flags always follow the reported ethertype (inner type when VLAN-tagged).
    function automatic eth_metadata_t build_meta(
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [15:0] etype,
        input logic [11:0] vid,
        input logic        vlan,
        input logic        runt
    );
        eth_metadata_t m;
        m.dst_mac   = dst;
        m.src_mac   = src;
        m.ethertype = etype;
        m.vlan_id   = vid;
        m.is_vlan   = vlan;
        m.is_ipv4   = (etype == ETYPE_IPV4);
        m.is_ipv6   = (etype == ETYPE_IPV6);
        m.is_arp    = (etype == ETYPE_ARP);
        m.runt      = runt;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_axis_reg_slice.sv
`default_nettype none
// ============================================================================
// Module  : eth_axis_reg_slice
// Brief   : One-stage AXI-Stream register slice carrying tdata and tlast.
// Revision: 1.0 - initial release
// ============================================================================
module eth_axis_reg_slice #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;

    // Upstream is held off during reset so nothing is accepted into a slice being flushed.
    assign s_axis_tready = rst_n && (!r_valid || m_axis_tready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (s_axis_tready) begin
            r_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                r_data <= s_axis_tdata;
                r_last <= s_axis_tlast;
            end
        end
    end

    assign m_axis_tdata  = r_data;
    assign m_axis_tvalid = r_valid;
    assign m_axis_tlast  = r_last;

endmodule
`default_nettype wire

// File: rtl/eth_frame_parser.sv
`default_nettype none
// ============================================================================
// Module  : eth_frame_parser
// Brief   : Inline AXI-S Ethernet header parser; MACs/EtherType on a sideband.
//           Define ETH_PARSER_VLAN_EN to parse one 802.1Q tag.
// Revision: 1.0 - initial release
// ============================================================================
module eth_frame_parser
    import eth_parser_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output eth_metadata_t     m_axis_tuser,
    output logic              m_axis_tuser_valid
);

    localparam logic [15:0] c_HDR_LAST = 16'(ETH_HDR_BYTES - 1);

    parse_state_t  r_state;
    parse_state_t  w_state_nxt;
    logic [15:0]   r_byte_cnt;
    logic [47:0]   r_dst;
    logic [47:0]   r_src;
    logic [15:0]   r_etype;
    logic [47:0]   w_dst_nxt;
    logic [47:0]   w_src_nxt;
    logic [15:0]   w_etype_nxt;
    logic [7:0]    w_byte;
    logic          w_accept;
    logic          w_first;
    logic          w_hdr_end;
    logic          w_emit;
    eth_metadata_t w_meta;
    eth_metadata_t r_meta;
    logic          r_meta_valid;

    eth_axis_reg_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    assign w_accept = s_axis_tvalid && s_axis_tready;
    assign w_byte   = s_axis_tdata[7:0];
    assign w_first  = (r_byte_cnt == 16'd0);

    // Next capture values include the byte being accepted, so metadata can be
    // registered on the same edge that accepts the header-completing byte.
    // Starting a frame zeroes every field so runts report uncaptured bytes as 0.
    always_comb begin
        w_dst_nxt   = w_first ? '0 : r_dst;
        w_src_nxt   = w_first ? '0 : r_src;
        w_etype_nxt = w_first ? '0 : r_etype;
        for (int i = 0; i < 6; i++) begin
            if (r_byte_cnt == 16'(i))     w_dst_nxt[8*(5-i) +: 8] = w_byte;
            if (r_byte_cnt == 16'(i + 6)) w_src_nxt[8*(5-i) +: 8] = w_byte;
        end
        if (r_byte_cnt == 16'd12) w_etype_nxt[15:8] = w_byte;
        if (r_byte_cnt == 16'd13) w_etype_nxt[7:0]  = w_byte;
    end

`ifdef ETH_PARSER_VLAN_EN
    localparam logic [15:0] c_VLAN_LAST = 16'(ETH_HDR_BYTES + 3);

    logic [11:0] r_vid;
    logic [15:0] r_inner;
    logic [11:0] w_vid_nxt;
    logic [15:0] w_inner_nxt;
    logic        w_outer_vlan;

    always_comb begin
        w_vid_nxt   = w_first ? '0 : r_vid;
        w_inner_nxt = w_first ? '0 : r_inner;
        if (r_byte_cnt == 16'd14) w_vid_nxt[11:8]    = w_byte[3:0];
        if (r_byte_cnt == 16'd15) w_vid_nxt[7:0]     = w_byte;
        if (r_byte_cnt == 16'd16) w_inner_nxt[15:8]  = w_byte;
        if (r_byte_cnt == 16'd17) w_inner_nxt[7:0]   = w_byte;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vid   <= '0;
            r_inner <= '0;
        end else if (w_accept) begin
            r_vid   <= w_vid_nxt;
            r_inner <= w_inner_nxt;
        end
    end

    assign w_outer_vlan = (w_etype_nxt == ETYPE_VLAN);
    assign w_hdr_end    = ((r_byte_cnt == c_HDR_LAST) && !w_outer_vlan) ||
                          (r_byte_cnt == c_VLAN_LAST);
    assign w_meta       = build_meta(w_dst_nxt, w_src_nxt,
                                     w_outer_vlan ? w_inner_nxt : w_etype_nxt,
                                     w_outer_vlan ? w_vid_nxt : 12'd0,
                                     w_outer_vlan, !w_hdr_end);
`else
    assign w_hdr_end = (r_byte_cnt == c_HDR_LAST);
    assign w_meta    = build_meta(w_dst_nxt, w_src_nxt, w_etype_nxt, 12'd0,
                                  (w_etype_nxt == ETYPE_VLAN), !w_hdr_end);
`endif

    // A frame strobes once: either when its header completes or, for a runt, at tlast.
    assign w_emit = w_accept && (r_state != ST_PAYLOAD) && (w_hdr_end || s_axis_tlast);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !s_axis_tlast) w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (w_accept) begin
                    if (s_axis_tlast)   w_state_nxt = ST_IDLE;
                    else if (w_hdr_end) w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_accept && s_axis_tlast) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_dst        <= '0;
            r_src        <= '0;
            r_etype      <= '0;
            r_meta       <= '0;
            r_meta_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_meta_valid <= w_emit;
            if (w_emit) r_meta <= w_meta;
            if (w_accept) begin
                r_dst   <= w_dst_nxt;
                r_src   <= w_src_nxt;
                r_etype <= w_etype_nxt;
                if (s_axis_tlast)                 r_byte_cnt <= '0;
                else if (r_byte_cnt != 16'hFFFF)  r_byte_cnt <= r_byte_cnt + 16'd1;
            end
        end
    end

    assign m_axis_tuser       = r_meta;
    assign m_axis_tuser_valid = r_meta_valid;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_frame_parser
// Brief   : Randomised self-checking bench for eth_frame_parser (default build).
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_frame_parser;
    import eth_parser_pkg::*;

    localparam int DATA_W = 64;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    eth_metadata_t     m_axis_tuser;
    logic              m_axis_tuser_valid;

    int n_checks = 0;
    int n_errors = 0;
    int n_strobes = 0;
    int n_out_beats = 0;
    int n_out_last = 0;
    int sink_mode = 0;
    int model_idx = 0;
    logic strobe_due = 1'b0;
    logic prev_acc = 1'b0;
    beat_t prev_beat;
    beat_t exp_q[$];
    eth_metadata_t meta_q[$];
    eth_metadata_t last_meta = '0;

    eth_frame_parser #(.DATA_W(DATA_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tuser       (m_axis_tuser),
        .m_axis_tuser_valid (m_axis_tuser_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    // Reference metadata straight from the header layout; missing bytes read as 0.
    function automatic eth_metadata_t model_meta(input bq_t f);
        logic [7:0]    h[14];
        eth_metadata_t m;
        for (int i = 0; i < 14; i++) h[i] = (i < f.size()) ? f[i] : 8'h00;
        m           = '0;
        m.dst_mac   = {h[0], h[1], h[2], h[3], h[4], h[5]};
        m.src_mac   = {h[6], h[7], h[8], h[9], h[10], h[11]};
        m.ethertype = {h[12], h[13]};
        m.runt      = (f.size() < 14);
        m.is_ipv4   = (m.ethertype == 16'h0800);
        m.is_ipv6   = (m.ethertype == 16'h86DD);
        m.is_arp    = (m.ethertype == 16'h0806);
        m.is_vlan   = (m.ethertype == 16'h8100);
        return m;
    endfunction

    function automatic bq_t make_frame(input logic [47:0] dst, input logic [47:0] src,
                                       input logic [15:0] etype, input int len);
        bq_t        q;
        logic [7:0] h[14];
        for (int i = 0; i < 6; i++) begin
            h[i]     = dst[8*(5-i) +: 8];
            h[i + 6] = src[8*(5-i) +: 8];
        end
        h[12] = etype[15:8];
        h[13] = etype[7:0];
        for (int i = 0; i < len; i++) q.push_back((i < 14) ? h[i] : 8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic drive_beat(input logic [7:0] b, input logic last);
        logic [DATA_W-1:0] rnd;
        logic              hs;
        int                guard;
        rnd           = {$urandom, $urandom};
        rnd[7:0]      = b;
        s_axis_tdata  = rnd;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        hs            = 1'b0;
        guard         = 0;
        while (!hs && guard < 2000) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!hs) check("hs_timeout", 160'(hs), 160'(1));
    endtask

    task automatic send_frame(input bq_t f, input int gap, input int bubble_pct);
        meta_q.push_back(model_meta(f));
        for (int i = 0; i < f.size(); i++) begin
            if ($urandom_range(0, 99) < bubble_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            drive_beat(f[i], (i == f.size() - 1));
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("drain", 160'(exp_q.size()), 160'(0));
        check("meta_left", 160'(meta_q.size()), 160'(0));
        check("tuser_hold", 160'(m_axis_tuser), 160'(last_meta));
    endtask

    initial begin : p_sink
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ($urandom_range(0, 3) != 0);
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: everything observed at the negedge describes the handshake at the next posedge.
    initial begin : p_monitor
        beat_t         eb;
        eth_metadata_t em;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_idx  = 0;
                strobe_due = 1'b0;
                prev_acc   = 1'b0;
                last_meta  = '0;
            end else begin
                if (strobe_due || m_axis_tuser_valid) begin
                    check("strobe", 160'(m_axis_tuser_valid), 160'(strobe_due));
                    if (m_axis_tuser_valid) begin
                        n_strobes++;
                        check("meta_avail", 160'(meta_q.size() != 0), 160'(1));
                        if (meta_q.size() != 0) begin
                            em        = meta_q.pop_front();
                            last_meta = em;
                            check("meta", 160'(m_axis_tuser), 160'(em));
                        end
                    end
                end
                if (prev_acc) begin
                    check("lat_valid", 160'(m_axis_tvalid), 160'(1));
                    check("lat_beat", 160'({m_axis_tdata, m_axis_tlast}), 160'(prev_beat));
                end
                if (s_axis_tvalid)
                    check("s_ready", 160'(s_axis_tready), 160'(!m_axis_tvalid || m_axis_tready));
                if (m_axis_tvalid && m_axis_tready) begin
                    n_out_beats++;
                    if (m_axis_tlast) n_out_last++;
                    check("out_avail", 160'(exp_q.size() != 0), 160'(1));
                    if (exp_q.size() != 0) begin
                        eb = exp_q.pop_front();
                        check("out_beat", 160'({m_axis_tdata, m_axis_tlast}), 160'(eb));
                    end
                end
                prev_acc   = s_axis_tvalid && s_axis_tready;
                strobe_due = 1'b0;
                if (prev_acc) begin
                    prev_beat.data = s_axis_tdata;
                    prev_beat.last = s_axis_tlast;
                    exp_q.push_back(prev_beat);
                    strobe_due = (model_idx == 13) || (s_axis_tlast && model_idx < 13);
                    model_idx  = s_axis_tlast ? 0 : model_idx + 1;
                end
            end
        end
    end

    initial begin : p_watchdog
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        bq_t         f;
        bq_t         f2;
        logic [63:0] r1;
        logic [63:0] r2;
        int          s0;
        int          o0;
        int          l0;
        int          lens[4];

        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        sink_mode     = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mvalid", 160'(m_axis_tvalid), 160'(0));
        check("rst_mlast", 160'(m_axis_tlast), 160'(0));
        check("rst_mdata", 160'(m_axis_tdata), 160'(0));
        check("rst_tuser", 160'(m_axis_tuser), 160'(0));
        check("rst_tuser_valid", 160'(m_axis_tuser_valid), 160'(0));
        check("rst_sready", 160'(s_axis_tready), 160'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed 64-byte IPv4 frame, sink always ready
        s0 = n_strobes;
        o0 = n_out_beats;
        f  = make_frame(48'h001122334455, 48'h66778899AABB, 16'h0800, 64);
        send_frame(f, 2, 0);
        wait_drain();
        check("t1_beats", 160'(n_out_beats - o0), 160'(64));
        check("t1_strobes", 160'(n_strobes - s0), 160'(1));
        check("t1_ipv4", 160'(last_meta.is_ipv4 && !last_meta.runt), 160'(1));

        // 50 random frames, random sink back-pressure and gaps
        sink_mode = 1;
        s0 = n_strobes;
        l0 = n_out_last;
        for (int k = 0; k < 50; k++) begin
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            f  = make_frame(r1[47:0], r2[47:0], 16'h0800, int'($urandom_range(64, 256)));
            send_frame(f, int'($urandom_range(1, 10)), 10);
        end
        wait_drain();
        check("t2_tlast", 160'(n_out_last - l0), 160'(50));
        check("t2_strobes", 160'(n_strobes - s0), 160'(50));
        sink_mode = 0;

        // Short frames around the header boundary (runts and exact 14 bytes)
        lens = '{1, 10, 13, 14};
        for (int k = 0; k < 4; k++) begin
            s0 = n_strobes;
            o0 = n_out_beats;
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            f  = make_frame(r1[47:0], r2[47:0], 16'h0800, lens[k]);
            send_frame(f, 2, 0);
            wait_drain();
            check("short_beats", 160'(n_out_beats - o0), 160'(lens[k]));
            check("short_strobes", 160'(n_strobes - s0), 160'(1));
            check("short_runt", 160'(last_meta.runt), 160'(lens[k] < 14));
        end

        // Back-to-back IPv6 then ARP
        s0 = n_strobes;
        f  = make_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h86DD, 40);
        f2 = make_frame(48'hFFFFFFFFFFFF, 48'h0000DEADBEEF, 16'h0806, 42);
        send_frame(f, 0, 0);
        send_frame(f2, 0, 0);
        wait_drain();
        check("b2b_strobes", 160'(n_strobes - s0), 160'(2));
        check("b2b_arp", 160'(last_meta.is_arp), 160'(1));

        // 20-cycle sink stall mid-frame
        f = make_frame(48'h112233445566, 48'h778899AABBCC, 16'h0800, 64);
        fork
            send_frame(f, 2, 0);
            begin
                int g = 0;
                while (model_idx < 20 && g < 500) begin
                    @(posedge clk);
                    g++;
                end
                #2;
                sink_mode = 2;
                repeat (21) @(negedge clk);
                check("stall_sready", 160'(s_axis_tready), 160'(0));
                check("stall_mvalid", 160'(m_axis_tvalid), 160'(1));
                check("stall_qdepth", 160'(exp_q.size()), 160'(1));
                if (exp_q.size() != 0)
                    check("stall_hold", 160'({m_axis_tdata, m_axis_tlast}), 160'(exp_q[0]));
                @(posedge clk);
                #2;
                sink_mode = 0;
            end
        join
        wait_drain();

        // Reset while byte 5 of a frame is presented, then a fresh frame
        s0 = n_strobes;
        f  = make_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 64);
        for (int i = 0; i < 5; i++) drive_beat(f[i], 1'b0);
        s_axis_tdata[7:0] = f[5];
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_sready", 160'(s_axis_tready), 160'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        check("rst_mid_flush", 160'(m_axis_tvalid), 160'(0));
        check("rst_mid_tuser", 160'(m_axis_tuser), 160'(0));
        @(posedge clk);
        #1;
        check("rst_mid_nostrobe", 160'(n_strobes - s0), 160'(0));
        f = make_frame(48'h020000000001, 48'h020000000002, 16'h0800, 64);
        send_frame(f, 2, 0);
        wait_drain();
        check("rst_after_strobes", 160'(n_strobes - s0), 160'(1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
